// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/busy/done handshake and result bus for the BCD converter
interface bin_to_bcd_seq_if #(parameter int IN_W = 8, parameter int DIGITS = 3);
  logic start;
  logic [IN_W-1:0] bin;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] digits;
  logic overflow;
  modport master(output start, bin, input busy, done, digits, overflow);
  modport slave(input start, bin, output busy, done, digits, overflow);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary to BCD, one bit per clock, with
// leading-zero blanking and saturating overflow
module bin_to_bcd_seq #(
  parameter int IN_W = 8,
  parameter int DIGITS = 3,
  parameter int LZ_BLANK = 1,
  parameter logic [3:0] BLANK_CODE = 4'hA
) (
  input logic clk,
  input logic reset,
  bin_to_bcd_seq_if.slave bus
);
  // scratch covers every decimal digit of 2^IN_W-1 and at least DIGITS fields
  localparam int SN = (IN_W * 30103) / 100000 + 1;
  localparam int NS = SN > DIGITS ? SN : DIGITS;
  localparam int CW = IN_W + 4 * DIGITS + 1;
  localparam int CNT_W = $clog2(IN_W + 1);
  function automatic logic [CW-1:0] pow10(input int n);
    logic [CW-1:0] p;
    p = CW'(1);
    for (int i = 0; i < n; i++) p = p * CW'(10);
    return p;
  endfunction
  localparam logic [CW-1:0] LIMIT = pow10(DIGITS);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t state;
  logic [IN_W-1:0] sh;
  logic [4*NS-1:0] scr, adj;
  logic [4*DIGITS-1:0] shown;
  logic [CNT_W-1:0] cnt;
  logic ovf_p, lead;
  always_comb begin
    adj = scr;
    for (int i = 0; i < NS; i++)
      adj[4*i+:4] = scr[4*i+:4] >= 4'd5 ? scr[4*i+:4] + 4'd3 : scr[4*i+:4];
  end
  // walk down from the top field; blanking stops at the first nonzero digit or units
  always_comb begin
    lead = 1'b1;
    shown = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead = lead && (scr[4*i+:4] == 4'd0) && (i > 0) && (LZ_BLANK != 0);
      shown[4*i+:4] = lead ? BLANK_CODE : scr[4*i+:4];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sh <= '0;
      scr <= '0;
      cnt <= '0;
      ovf_p <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.overflow <= 1'b0;
      bus.digits <= {DIGITS{BLANK_CODE}};
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          sh <= bus.bin;
          scr <= '0;
          cnt <= CNT_W'(IN_W);
          ovf_p <= CW'(bus.bin) >= LIMIT;
          bus.busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {scr, sh} <= {adj, sh} << 1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= LOAD;
        end
        LOAD: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          bus.overflow <= ovf_p;
          bus.digits <= ovf_p ? {DIGITS{4'h9}} : shown;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
